// File: rtl/wb_bus_ctrl.sv
// wb_bus_ctrl
// Downstream controller for the shared Wishbone bus. Accepts the single
// granted master transaction, decodes one of four slaves from adr[31:30],
// strobes it with latched address/data, and returns the slave's read data
// and ack to the master. An access the slave never answers is closed with a
// timeout error response, so a missing slave cannot hang the bus.
//
// Transfer sequence:
//   IDLE -> REQ  : request latched, one-hot slave strobe raised
//   REQ  -> RESP : selected slave acked, or timer reached TIMEOUT-1
//   REQ  -> IDLE : master dropped cyc/stb (arbiter re-grant), silent abort
//   RESP -> HOLD : registered m_ack (and m_err) pulse is issued
//   HOLD -> IDLE : master strobe seen low, so a lingering strobe is never
//                  taken as a second transaction

module wb_bus_ctrl #(
    parameter int unsigned TIMEOUT  = 64,           // legal 2..255
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,

    // Master side (from the arbiter)
    input  logic        m_cyc,
    input  logic        m_stb,
    input  logic        m_we,
    input  logic [31:0] m_adr,
    input  logic [31:0] m_dat_i,
    output logic [31:0] m_dat_o,
    output logic        m_ack,
    output logic        m_err,

    // Slave side
    output logic [3:0]  s_cyc,
    output logic [3:0]  s_stb,
    output logic        s_we,
    output logic [31:0] s_adr,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i0,
    input  logic [31:0] s_dat_i1,
    input  logic [31:0] s_dat_i2,
    input  logic [31:0] s_dat_i3,
    input  logic [3:0]  s_ack,

    // Timeout statistics
    output logic [7:0]  to_cnt,
    output logic [31:0] err_adr
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    // Timer value in the last strobe cycle the slave is allowed to answer in.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [1:0]  sel;          // latched slave index
    logic [7:0]  timer;        // strobe cycles elapsed in REQ
    logic        err_flag;     // current access ended by timeout
    logic [31:0] rd_data;      // read data of the selected slave

    logic        m_req;
    logic        ack_sel;
    logic        req_accept;
    logic        req_abort;
    logic        req_done;
    logic        req_timeout;

    assign m_req   = m_cyc & m_stb;
    assign ack_sel = s_ack[sel];   // acks from unselected slaves are ignored

    // Events that start or end a slave access. Abort and completion are
    // mutually exclusive (both need a defined m_req), and an ack in the
    // final timer cycle wins over the timeout.
    assign req_accept  = (state == ST_IDLE) && m_req;
    assign req_abort   = (state == ST_REQ) && !m_req;
    assign req_done    = (state == ST_REQ) && m_req && ack_sel;
    assign req_timeout = (state == ST_REQ) && m_req && !ack_sel
                         && (timer == TIMER_LAST);

    // Strobe is identical to cycle on every slave port.
    assign s_stb = s_cyc;

    // Next-state decode for the transfer sequence.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_accept) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (req_abort)                      state_nxt = ST_IDLE;
                else if (req_done || req_timeout)   state_nxt = ST_RESP;
            end
            ST_RESP: begin
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (!m_stb) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read-data multiplexer driven by the latched slave index.
    always_comb begin
        rd_data = s_dat_i0;
        case (sel)
            2'd1:    rd_data = s_dat_i1;
            2'd2:    rd_data = s_dat_i2;
            2'd3:    rd_data = s_dat_i3;
            default: rd_data = s_dat_i0;
        endcase
    end

    // State register; reset wins over every state and aborts open accesses.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the accepted request; the slave side sees only these copies, so
    // later master address/data changes cannot disturb the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel     <= 2'd0;
            s_we    <= 1'b0;
            s_adr   <= 32'd0;
            s_dat_o <= 32'd0;
        end else if (req_accept) begin
            sel     <= m_adr[31:30];
            s_we    <= m_we;
            s_adr   <= m_adr;
            s_dat_o <= m_dat_i;
        end
    end

    // Strobe timer: cleared on acceptance, counts every cycle spent in REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= 8'd0;
        end else if (req_accept) begin
            timer <= 8'd0;
        end else if (state == ST_REQ) begin
            timer <= timer + 8'd1;
        end
    end

    // One-hot slave cycle/strobe: raised the cycle after acceptance, dropped
    // the cycle after ack, timeout or master abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_cyc <= 4'd0;
        end else if (req_accept) begin
            s_cyc <= 4'b0001 << m_adr[31:30];
        end else if (req_abort || req_done || req_timeout) begin
            s_cyc <= 4'd0;
        end
    end

    // Master response: capture read data or ERR_DATA at completion, then
    // pulse m_ack (with m_err on timeout) for one cycle out of RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_dat_o  <= 32'd0;
            err_flag <= 1'b0;
            m_ack    <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            m_ack <= (state == ST_RESP);
            m_err <= (state == ST_RESP) && err_flag;
            if (req_accept) begin
                err_flag <= 1'b0;
            end
            if (req_done) begin
                err_flag <= 1'b0;
                if (!s_we) m_dat_o <= rd_data;
            end else if (req_timeout) begin
                err_flag <= 1'b1;
                if (!s_we) m_dat_o <= ERR_DATA;
            end
        end
    end

    // Timeout statistics: saturating count and address of the latest timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= 8'd0;
            err_adr <= 32'd0;
        end else if (req_timeout) begin
            err_adr <= s_adr;
            if (to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
        end
    end

endmodule
